// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter (ALU vs load) with round-robin on contention; latency 1 cycle from grant to RegWrite.
// Backpressure: a requester holds valid/rd/data until its combinational ready; stall withholds all grants, nothing is buffered.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              stall,
    input  logic              clr_count,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              wb_src,
    output logic [CNT_W-1:0]  conflict_count
);

    logic              prioPtr;
    logic              grantA;
    logic              grantB;
    logic              contended;
    logic [ADDR_W-1:0] selRd;
    logic [DATA_W-1:0] selData;

    // Grants are gated by reset so both readies read 0 while reset is held.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (reset && !stall) begin
            if (a_valid && (!b_valid || !prioPtr)) begin
                grantA = 1'b1;
            end else if (b_valid) begin
                grantB = 1'b1;
            end
        end
    end

    assign a_ready   = grantA;
    assign b_ready   = grantB;
    assign contended = a_valid && b_valid && !stall;
    assign selRd     = grantB ? b_rd : a_rd;
    assign selData   = grantB ? b_data : a_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prioPtr   <= 1'b0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            wb_src    <= 1'b0;
        end else if (grantA || grantB) begin
            prioPtr   <= grantA;
            RegWrite  <= (selRd != '0);
            WriteReg  <= selRd;
            WriteData <= selData;
            wb_src    <= grantB;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Saturating contention counter; clear wins over a same-cycle increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_count <= '0;
        end else if (clr_count) begin
            conflict_count <= '0;
        end else if (contended && (conflict_count != {CNT_W{1'b1}})) begin
            conflict_count <= conflict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a rule-level reference model.
module tb_regfile_write_arbiter;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset;
    logic              a_valid, b_valid, a_ready, b_ready;
    logic [ADDR_W-1:0] a_rd, b_rd;
    logic [DATA_W-1:0] a_data, b_data;
    logic              stall, clr_count;
    logic              RegWrite, wb_src;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [CNT_W-1:0]  conflict_count;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .stall(stall), .clr_count(clr_count),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .wb_src(wb_src), .conflict_count(conflict_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int nCmp  = 0;
    int nFail = 0;

    // Reference model: who last won, what the register file last saw, how many contended cycles.
    logic        mPtr;
    logic        mRegWrite;
    logic [63:0] mWriteReg;
    logic [63:0] mWriteData;
    logic        mSrc;
    int          mCnt;
    logic        lastGA, lastGB;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPtr = 1'b0; mRegWrite = 1'b0; mWriteReg = '0; mWriteData = '0; mSrc = 1'b0; mCnt = 0;
    endtask

    task automatic checkOuts();
        chk("RegWrite", 64'(RegWrite), 64'(mRegWrite));
        chk("WriteReg", 64'(WriteReg), mWriteReg);
        chk("WriteData", 64'(WriteData), mWriteData);
        chk("wb_src", 64'(wb_src), 64'(mSrc));
        chk("conflict_count", 64'(conflict_count), 64'(mCnt));
    endtask

    // Inputs are already driven; check readies, let one edge pass, check registered results.
    task automatic cycle();
        logic ga, gb;
        #1;
        ga = 1'b0; gb = 1'b0;
        if (!stall) begin
            if (a_valid && b_valid) begin
                if (mPtr) gb = 1'b1; else ga = 1'b1;
            end else if (a_valid) ga = 1'b1;
            else if (b_valid) gb = 1'b1;
        end
        chk("a_ready", 64'(a_ready), 64'(ga));
        chk("b_ready", 64'(b_ready), 64'(gb));
        lastGA = ga; lastGB = gb;
        @(posedge clock);
        if (ga || gb) begin
            mPtr       = ga;
            mWriteReg  = 64'(ga ? a_rd : b_rd);
            mWriteData = 64'(ga ? a_data : b_data);
            mSrc       = gb;
            mRegWrite  = (mWriteReg != 0);
        end else begin
            mRegWrite = 1'b0;
        end
        if (clr_count) mCnt = 0;
        else if (a_valid && b_valid && !stall && mCnt < CNT_MAX) mCnt++;
        @(negedge clock);
        checkOuts();
    endtask

    task automatic idleInputs();
        a_valid = 0; b_valid = 0; a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        stall = 0; clr_count = 0;
    endtask

    task automatic doReset();
        @(negedge clock);
        idleInputs();
        reset = 1'b0;
        modelReset();
        #1 checkOuts();
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [ADDR_W-1:0] wrSeq [4];
    int                satCnt;

    initial begin
        idleInputs();
        modelReset();
        reset   = 1'b0;
        a_valid = 1'b1; a_rd = 5'd5; b_valid = 1'b1; b_rd = 5'd6;
        #3;
        checkOuts();
        chk("rst_a_ready", 64'(a_ready), 64'(0));
        chk("rst_b_ready", 64'(b_ready), 64'(0));
        @(negedge clock);
        idleInputs();
        reset = 1'b1;

        // Single A write
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        chk("singleA_RegWrite", 64'(RegWrite), 64'(1));
        chk("singleA_WriteData", 64'(WriteData), 64'hDEADBEEF);
        idleInputs();
        cycle();

        // Contention from a fresh reset: A,B,A,B
        doReset();
        a_valid = 1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1; b_rd = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            cycle();
            wrSeq[i] = WriteReg;
        end
        chk("cont_seq0", 64'(wrSeq[0]), 64'(1));
        chk("cont_seq1", 64'(wrSeq[1]), 64'(2));
        chk("cont_seq2", 64'(wrSeq[2]), 64'(1));
        chk("cont_seq3", 64'(wrSeq[3]), 64'(2));
        chk("cont_count", 64'(conflict_count), 64'(4));

        // Write to x0 is accepted but suppressed
        a_valid = 0; b_valid = 1; b_rd = 5'd0; b_data = 32'h1234;
        cycle();
        chk("x0_RegWrite", 64'(RegWrite), 64'(0));
        chk("x0_WriteData", 64'(WriteData), 64'h1234);
        chk("x0_wb_src", 64'(wb_src), 64'(1));

        // Stall with both pending, then release
        a_valid = 1; a_rd = 5'd3; a_data = 32'h33;
        b_valid = 1; b_rd = 5'd4; b_data = 32'h44;
        stall = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_count", 64'(conflict_count), 64'(4));
        stall = 0;
        cycle();
        chk("stall_first_src", 64'(wb_src), 64'(0));

        // Saturation then clear while still contended
        for (int i = 0; i < 20; i++) cycle();
        satCnt = int'(conflict_count);
        chk("sat_count", 64'(satCnt), 64'(15));
        clr_count = 1;
        cycle();
        chk("clr_count", 64'(conflict_count), 64'(0));
        clr_count = 0;

        // Asynchronous reset landing mid-transfer
        idleInputs();
        a_valid = 1; a_rd = 5'd9; a_data = 32'hA5A5;
        cycle();
        a_rd = 5'd10; a_data = 32'h5A5A;
        #2 reset = 1'b0;
        modelReset();
        #1;
        checkOuts();
        chk("arst_a_ready", 64'(a_ready), 64'(0));
        chk("arst_b_ready", 64'(b_ready), 64'(0));
        @(negedge clock);
        a_valid = 0;
        reset = 1'b1;
        cycle();
        chk("arst_no_pulse", 64'(RegWrite), 64'(0));

        // Randomized traffic; a pending requester holds its request until granted
        idleInputs();
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || lastGA) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = ADDR_W'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || lastGB) begin
                b_valid = 1'($urandom_range(0, 1));
                b_rd    = ADDR_W'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            stall     = ($urandom_range(0, 3) == 0);
            clr_count = ($urandom_range(0, 15) == 0);
            lastGA = 1'b0; lastGB = 1'b0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
